booth_seq_mul16: RTL and testbench

BOOTH_SEQ_MUL16 -- requirements
Module: booth_seq_mul16

---
 rtl/booth_seq_mul16.sv | 130 +++++++++++++
 tb/tb_booth_seq_mul16.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mul16.sv
// rtl/booth_seq_mul16.sv - sequential radix-4 Booth signed multiplier
//
// Purpose: multiplies two N-bit two's-complement operands, retiring one
// radix-4 Booth digit per clock (N/2 iterations), and presents the exact
// 2N-bit signed product with a one-cycle done pulse.
//
// Ports:
//   clk    in   1    clock, rising edge
//   rst_n  in   1    asynchronous active-low reset
//   start  in   1    request a multiply (accepted only when idle)
//   in1    in   N    multiplicand, signed
//   in2    in   N    multiplier, signed
//   out1   out  2N   signed product, held until the next result
//   busy   out  1    high while an operation is in flight (CALC or DONE)
//   done   out  1    one-cycle pulse; out1 valid in that cycle

module booth_seq_mul16 #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   in1,
    input  logic [N-1:0]   in2,
    output logic [2*N-1:0] out1,
    output logic           busy,
    output logic           done
);

    localparam int ITER = N / 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [N-1:0]    mcand_q;
    logic [N-1:0]    mplier_q;
    logic [2*N-1:0]  acc_q;
    logic [CW-1:0]   cnt_q;
    logic [2*N-1:0]  out1_q;
    logic            busy_q;
    logic            done_q;

    logic [N:0]      mplier_ext;
    logic [N:0]      trip_src;
    logic [2:0]      triplet;
    logic [2*N-1:0]  mc_ext;
    logic [2*N-1:0]  pp_base;
    logic [2*N-1:0]  pp_shifted;
    logic [2*N-1:0]  acc_d;

    // Append the implicit m[-1]=0 below the multiplier, then shift the
    // current digit's three bits down to [2:0].
    always_comb begin
        mplier_ext = {mplier_q, 1'b0};
        trip_src   = mplier_ext >> {cnt_q, 1'b0};
        triplet    = trip_src[2:0];
    end

    // The partial product is built directly at accumulator width so that
    // -2 * (-2^(N-1)) = +2^N is represented exactly instead of wrapping.
    always_comb begin
        mc_ext = {{N{mcand_q[N-1]}}, mcand_q};
        case (triplet)
            3'b001, 3'b010: pp_base = mc_ext;
            3'b011:         pp_base = mc_ext << 1;
            3'b100:         pp_base = -(mc_ext << 1);
            3'b101, 3'b110: pp_base = -mc_ext;
            default:        pp_base = '0;
        endcase
        pp_shifted = pp_base << {cnt_q, 1'b0};
        acc_d      = acc_q + pp_shifted;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out1_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= in1;
                        mplier_q <= in2;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // out1 only ever sees the finished sum.
                        out1_q  <= acc_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out1 = out1_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_booth_seq_mul16.sv
// tb/tb_booth_seq_mul16.sv - self-checking bench for booth_seq_mul16

module tb_booth_seq_mul16;

    localparam int N   = 16;
    localparam int LAT = N / 2 + 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  in1;
    logic [N-1:0]  in2;
    logic [2*N-1:0] out1;
    logic          busy;
    logic          done;

    int checks;
    int errors;

    booth_seq_mul16 #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .out1  (out1),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Protocol-level model: an accepted request keeps the block busy for
    // LAT cycles, the last of which carries done and the exact product.
    int            rem;
    logic [31:0]   exp_out;
    logic [31:0]   exp_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= 0;
            exp_out  <= '0;
            exp_pend <= '0;
        end else if (rem == 0) begin
            if (start) begin
                rem      <= LAT;
                exp_pend <= 32'(longint'($signed(in1)) * longint'($signed(in2)));
            end
        end else begin
            rem <= rem - 1;
            if (rem == 2) exp_out <= exp_pend;
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, rem != 0});
        chk("done", {31'd0, done}, {31'd0, rem == 1});
        chk("out1", out1, exp_out);
        if (done && !busy) chk("done_while_idle", 32'd1, 32'd0);
    end

    task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] lit, input string name);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        in1   = a;
        in2   = b;
        @(negedge clk);
        start = 1'b0;
        in1   = 16'($urandom);
        in2   = 16'($urandom);
        cyc   = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, 32'(cyc), 32'd9);
        chk(name, out1, lit);
        @(negedge clk);
    endtask

    int   last_done;
    int   seen_done;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        in1    = '0;
        in2    = '0;
        repeat (3) @(negedge clk);
        chk("reset_out1", out1, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_one(16'd3,     16'd5,     32'h0000000F, "3x5");
        run_one(16'h8000,  16'h8000,  32'h40000000, "min_x_min");
        run_one(16'h7FFF,  16'h8000,  32'hC0008000, "max_x_min");
        run_one(16'hFFFF,  16'hFFFF,  32'h00000001, "m1_x_m1");
        run_one(16'h1234,  16'h0000,  32'h00000000, "x_zero");
        run_one(16'h7FFF,  16'h7FFF,  32'h3FFF0001, "max_x_max");
        run_one(16'h8000,  16'h0001,  32'hFFFF8000, "min_x_one");
        run_one(16'd7,     16'hFFFD,  32'hFFFFFFEB, "7_x_m3");

        // Abort in the 4th CALC cycle.
        @(negedge clk);
        start = 1'b1;
        in1   = 16'd100;
        in2   = 16'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out1", out1, 32'h0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        #1 rst_n = 1'b1;
        seen_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        run_one(16'd7, 16'hFFFD, 32'hFFFFFFEB, "after_abort");

        // start held high with operands changing every cycle.
        last_done = -1;
        start     = 1'b1;
        for (int k = 0; k < 3000 * 10 + 5; k++) begin
            @(negedge clk);
            if (done) begin
                if (last_done >= 0) chk("throughput", 32'(k - last_done), 32'd10);
                last_done = k;
            end
            in1 = 16'($urandom);
            in2 = 16'($urandom);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
